// File: rtl/data_memory_bytelane.sv
// Byte-addressable little-endian data memory for the RV32I load/store unit.
// Combinational loads, byte-lane stores, fault decode, post-reset clearing sweep.
module data_memory_bytelane #(
  parameter int    DEPTH_WORDS    = 32,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = "",
  parameter int    ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [31:0]      addr,
  input  logic [2:0]       funct3,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             misaligned,
  output logic             out_of_range,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              access;
  logic              is_half;
  logic              is_word;
  logic              f3_illegal;
  logic              fault;
  logic              do_store;
  logic [AW-1:0]     word_idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [3:0]        be;
  logic [31:0]       wd;

  assign word_idx = addr[AW+1:2];
  assign lane     = addr[1:0];
  assign busy     = (state_q == CLEAR);

  always_comb begin
    access     = (we | re) & (state_q == READY);
    is_half    = (funct3[1:0] == 2'b01);
    is_word    = (funct3[1:0] == 2'b10);
    // 011/110/111 are never legal; the unsigned forms 100/101 have no store meaning.
    f3_illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11) | (we & funct3[2]);
    misaligned = access & (f3_illegal | (is_half & addr[0]) | (is_word & (lane != 2'b00)));
    // Any set bit above the array span faults, so high addresses never alias.
    out_of_range = access & ((addr >> (AW + 2)) != 32'd0);
    fault      = misaligned | out_of_range;
    do_store   = we & access & ~fault;
  end

  always_comb begin
    rd_word = mem[word_idx];
    rd_byte = 8'(rd_word >> {lane, 3'b000});
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    rdata   = 32'd0;
    if (re & access & ~fault) begin
      case (funct3)
        3'b000:  rdata = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  rdata = {24'd0, rd_byte};
        3'b001:  rdata = {{16{rd_half[15]}}, rd_half};
        3'b101:  rdata = {16'd0, rd_half};
        3'b010:  rdata = rd_word;
        default: rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    be = 4'b0000;
    wd = wdata;
    case (funct3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!do_store) be = 4'b0000;
  end

  // Array has no reset of its own; the sweep is the only way it gets cleared.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][i*8 +: 8] <= wd[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    err_count_d = err_count_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH_WORDS - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = READY;
    endcase
    if (fault && (err_count_q != {ERR_W{1'b1}})) err_count_d = err_count_q + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state_q <= CLEAR;
      else                state_q <= READY;
      clr_ptr_q   <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;

endmodule
